vga_reg_mirror: RTL and testbench
=================================

VGA_REG_MIRROR -- requirements
Module: vga_reg_mirror

Interface
REQ-001 SHALL have parameter REGS, default 32, number of mirrored registers (fixed 32; index width 5).
REQ-002 SHALL have port clk  input  1  system clock, single clock domain.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cpu_we  input  1  CPU register-file write strobe.
REQ-005 SHALL have port cpu_wa  input  5  CPU register-file write address.
REQ-006 SHALL have port cpu_wd  input  32  CPU register-file write data.
REQ-007 SHALL have port snap_req  input  1  single-cycle request to copy live bank to display bank.
REQ-008 SHALL have port vsync  input  1  VGA vertical sync from the debug screen, active-low pulse.
REQ-009 SHALL have port regAddr  input  5  display-side register index from the debug screen.
REQ-010 SHALL have port regData  output  32  display-side register value to the debug screen.
REQ-011 SHALL have port busy  output  1  snapshot copy in progress.
REQ-012 SHALL have port snap_done  output  1  one-cycle pulse when a copy completes.

Function
REQ-013 SHALL hold two 32x32 banks: live (written by CPU) and display (read by screen).
REQ-014 SHALL write cpu_wd into live[cpu_wa] on a clk edge with cpu_we=1, except cpu_wa=0 (live[0] stays 0).
REQ-015 SHALL register regData <= display[regAddr] every cycle (1-cycle read latency, no enable).
REQ-016 SHALL implement FSM states IDLE and COPY; IDLE->COPY on accepted request, index cleared to 0.
REQ-017 SHALL in COPY copy live[idx] to display[idx] one word per cycle, idx 0..31, 32 cycles total.
REQ-018 SHALL on idx=31 copied: return to IDLE, pulse snap_done one cycle, busy=0 from that cycle.
REQ-019 SHALL drive busy=1 in every COPY cycle, 0 in IDLE.
REQ-020 SHALL, on simultaneous cpu_we to live[k] and copy of index k, copy the old value (read-before-write).
REQ-021 SHALL latch a request arriving while busy into one pending flag; extra requests while pending are dropped.
REQ-022 SHALL, if pending set at completion, go COPY->COPY with idx=0, still pulse snap_done, clear pending.
REQ-023 SHALL let the display bank change only through the copy engine; screen reads during COPY see a mix of old/new words.

Reset
REQ-024 SHALL on resetn=0 immediately clear both banks, regData=0, busy=0, snap_done=0, pending=0, FSM=IDLE, idx=0.
REQ-025 SHALL abort an in-progress copy on reset with no snap_done pulse.
REQ-026 SHALL accept requests from the first clk edge after resetn deasserts.

Configuration
REQ-027 SHALL honour macro VGA_REG_MIRROR_VSYNC_SNAP_EN: when defined, a registered falling edge of vsync (1 then 0 on consecutive edges) counts as a request, OR-ed with snap_req; vsync edge detector resets to 1.
REQ-028 SHALL, without VGA_REG_MIRROR_VSYNC_SNAP_EN, ignore vsync entirely; only snap_req triggers copies.

Verification
REQ-029 SHALL cover: write live[5]=32'hDEADBEEF, pulse snap_req, wait -> busy high 32 cycles, snap_done one pulse, regAddr=5 gives 32'hDEADBEEF one cycle later.
REQ-030 SHALL cover: cpu_we with cpu_wa=0, cpu_wd=32'hFFFFFFFF then snap -> regAddr=0 reads 32'h0.
REQ-031 SHALL cover: snap_req at copy cycle 10 plus again at cycle 12 -> exactly two copies back-to-back, 64 busy cycles, two snap_done pulses.
REQ-032 SHALL cover: during COPY write live[3]=32'h1 in the cycle idx=3 -> display[3] holds old value; next snap gives 32'h1.
REQ-033 SHALL cover: resetn low at copy cycle 16 -> all outputs 0 immediately, regData for any regAddr 0 after release, no snap_done.
REQ-034 SHALL cover with VGA_REG_MIRROR_VSYNC_SNAP_EN defined: vsync 1->0 -> copy starts, busy rises two cycles later; undefined: same stimulus -> busy stays 0.

Source files
------------

// File: rtl/vga_reg_mirror.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_reg_mirror: CPU register file mirror with a display-side snapshot    |
// | bank. Optional vsync-triggered snapshot: VGA_REG_MIRROR_VSYNC_SNAP_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_reg_mirror #(
  parameter int REGS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_wa,
  input  logic [31:0] cpu_wd,
  input  logic        snap_req,
  input  logic        vsync,
  input  logic [4:0]  regAddr,
  output logic [31:0] regData,
  output logic        busy,
  output logic        snap_done
);

  localparam int                 c_IDX_W    = 5;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(REGS - 1);
  localparam logic [0:0]         c_ST_IDLE  = 1'b0;
  localparam logic [0:0]         c_ST_COPY  = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_IDX_W-1:0] r_idx;
  logic [c_IDX_W-1:0] w_idx_nxt;
  logic               r_pending;
  logic               w_pending_nxt;
  logic               r_snap_done;
  logic               w_done_nxt;
  logic               w_req;
  logic               w_copy_en;
  logic [31:0]        r_regdata;
  logic [31:0]        w_live [REGS];
  logic [31:0]        w_disp [REGS];

`ifdef VGA_REG_MIRROR_VSYNC_SNAP_EN
  logic r_vsync_q;
  logic r_vsync_fall;

  // Falling edge is registered, so a copy starts two edges after vsync drops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vsync_q    <= 1'b1;
      r_vsync_fall <= 1'b0;
    end else begin
      r_vsync_q    <= vsync;
      r_vsync_fall <= r_vsync_q & ~vsync;
    end
  end

  assign w_req = snap_req | r_vsync_fall;
`else
  logic w_unused_vsync;
  assign w_unused_vsync = vsync;
  assign w_req          = snap_req;
`endif

  // Both banks update on the same edge, so the copy always sees the pre-write live word.
  for (genvar k = 0; k < REGS; k++) begin : g_bank
    if (k == 0) begin : g_zero
      assign w_live[k] = '0;
    end else begin : g_word
      logic [31:0] r_live;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_live <= '0;
        end else if (cpu_we && (cpu_wa == c_IDX_W'(k))) begin
          r_live <= cpu_wd;
        end
      end
      assign w_live[k] = r_live;
    end

    logic [31:0] r_disp;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_disp <= '0;
      end else if (w_copy_en && (r_idx == c_IDX_W'(k))) begin
        r_disp <= w_live[k];
      end
    end
    assign w_disp[k] = r_disp;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_regdata <= '0;
    end else begin
      r_regdata <= w_disp[regAddr];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= c_ST_IDLE;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_snap_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_pending   <= w_pending_nxt;
      r_snap_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pending_nxt = r_pending;
    w_done_nxt    = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = c_ST_COPY;
          w_idx_nxt   = '0;
        end
      end
      c_ST_COPY: begin
        if (r_idx == c_LAST_IDX) begin
          w_done_nxt    = 1'b1;
          w_idx_nxt     = '0;
          w_pending_nxt = 1'b0;
          // A request landing on the final word rolls straight into the next copy.
          w_state_nxt   = (r_pending || w_req) ? c_ST_COPY : c_ST_IDLE;
        end else begin
          w_idx_nxt     = r_idx + 1'b1;
          w_pending_nxt = r_pending | w_req;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_copy_en = (r_state == c_ST_COPY);
    busy      = (r_state == c_ST_COPY);
  end

  assign regData   = r_regdata;
  assign snap_done = r_snap_done;

endmodule
`default_nettype wire

// File: tb/tb_vga_reg_mirror.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_reg_mirror: directed scenarios plus random traffic against a      |
// | behavioural bank/copy model. Revision: 1.0                               |
// +--------------------------------------------------------------------------+
module tb_vga_reg_mirror;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_we = 1'b0;
  logic [4:0]  cpu_wa = '0;
  logic [31:0] cpu_wd = '0;
  logic        snap_req = 1'b0;
  logic        vsync = 1'b1;
  logic [4:0]  regAddr = '0;
  logic [31:0] regData;
  logic        busy;
  logic        snap_done;

  int checks = 0;
  int failures = 0;
  int bcount = 0;
  int dcount = 0;

  logic [31:0] live_m [32];
  logic [31:0] disp_m [32];
  logic [31:0] rd_m;
  int          pos_m;
  bit          pend_m;
  bit          done_m;
  bit          req_m;
`ifdef VGA_REG_MIRROR_VSYNC_SNAP_EN
  bit          vs_prev_m;
  bit          vs_fall_m;
`endif

  vga_reg_mirror #(.REGS(32)) dut (
    .clk(clk), .resetn(resetn), .cpu_we(cpu_we), .cpu_wa(cpu_wa), .cpu_wd(cpu_wd),
    .snap_req(snap_req), .vsync(vsync), .regAddr(regAddr), .regData(regData),
    .busy(busy), .snap_done(snap_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pos_m is the word being copied this cycle, -1 when no copy runs.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        live_m[i] = '0;
        disp_m[i] = '0;
      end
      rd_m = '0; pos_m = -1; pend_m = 0; done_m = 0;
`ifdef VGA_REG_MIRROR_VSYNC_SNAP_EN
      vs_prev_m = 1; vs_fall_m = 0;
`endif
    end else begin
      req_m = snap_req;
`ifdef VGA_REG_MIRROR_VSYNC_SNAP_EN
      req_m = req_m | vs_fall_m;
      vs_fall_m = vs_prev_m & ~vsync;
      vs_prev_m = vsync;
`endif
      rd_m   = disp_m[regAddr];
      done_m = (pos_m == 31);
      if (pos_m >= 0) disp_m[pos_m] = live_m[pos_m];
      if (cpu_we && cpu_wa != 5'd0) live_m[cpu_wa] = cpu_wd;
      if (pos_m < 0) begin
        if (req_m) pos_m = 0;
      end else if (pos_m == 31) begin
        if (pend_m || req_m) begin
          pos_m = 0; pend_m = 0;
        end else begin
          pos_m = -1;
        end
      end else begin
        pos_m++;
        if (req_m) pend_m = 1;
      end
    end
    #1;
    check("regData", regData, rd_m);
    check("busy", 32'(busy), 32'(pos_m >= 0));
    check("snap_done", 32'(snap_done), 32'(done_m));
    if (busy) bcount++;
    if (snap_done) dcount++;
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cpu_we = 1; cpu_wa = a; cpu_wd = d;
    @(negedge clk);
    cpu_we = 0;
  endtask

  task automatic snap();
    snap_req = 1;
    @(negedge clk);
    snap_req = 0;
  endtask

  task automatic wait_done(input int maxc);
    for (int n = 0; n < maxc; n++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("wait_timeout", 32'(busy), 32'd0);
  endtask

  task automatic readchk(input logic [4:0] a, input logic [31:0] exp, input string name);
    regAddr = a;
    @(negedge clk);
    check(name, regData, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    check("rst_regData", regData, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(snap_done), 32'd0);

    // Basic snapshot of one word
    wr(5'd5, 32'hDEADBEEF);
    bcount = 0; dcount = 0;
    snap();
    wait_done(100);
    check("single_busy_cycles", bcount, 32);
    check("single_done_pulses", dcount, 1);
    check("model_disp5", disp_m[5], 32'hDEADBEEF);
    readchk(5'd5, 32'hDEADBEEF, "read5");

    // Register 0 is hardwired to zero
    wr(5'd0, 32'hFFFFFFFF);
    snap();
    wait_done(100);
    readchk(5'd0, 32'h0, "read0_zero");

    // Requests during a copy: one is queued, the second dropped
    bcount = 0; dcount = 0;
    snap();
    repeat (10) @(negedge clk);
    snap();
    @(negedge clk);
    snap();
    wait_done(200);
    check("b2b_busy_cycles", bcount, 64);
    check("b2b_done_pulses", dcount, 2);

    // Write colliding with the copy of the same index
    wr(5'd3, 32'hAAAA5555);
    snap();
    wait_done(100);
    snap();
    repeat (3) @(negedge clk);
    wr(5'd3, 32'h1);
    wait_done(100);
    readchk(5'd3, 32'hAAAA5555, "rbw_old");
    check("model_disp3", disp_m[3], 32'hAAAA5555);
    snap();
    wait_done(100);
    readchk(5'd3, 32'h1, "rbw_new");

    // Reset in the middle of a copy
    snap();
    repeat (16) @(negedge clk);
    #2 resetn = 0;
    #1;
    check("arst_regData", regData, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(snap_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
    dcount = 0;
    readchk(5'd5, 32'd0, "arst_read5");
    readchk(5'd3, 32'd0, "arst_read3");
    readchk(5'd31, 32'd0, "arst_read31");
    repeat (40) @(negedge clk);
    check("arst_no_done", dcount, 0);

    // Vsync-triggered snapshot
    vsync = 0;
    @(negedge clk);
    check("vs_edge1_busy", 32'(busy), 32'd0);
    @(negedge clk);
`ifdef VGA_REG_MIRROR_VSYNC_SNAP_EN
    check("vs_busy", 32'(busy), 32'd1);
`else
    check("vs_busy", 32'(busy), 32'd0);
`endif
    vsync = 1;
    wait_done(100);

    // Random traffic, checked cycle by cycle by the model
    for (int c = 0; c < 4000; c++) begin
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_wa   = 5'($urandom);
      cpu_wd   = $urandom;
      snap_req = ($urandom_range(0, 39) == 0);
      regAddr  = 5'($urandom);
      if ($urandom_range(0, 59) == 0) vsync = ~vsync;
      resetn   = !($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    resetn = 1; cpu_we = 0; snap_req = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
